// File: rtl/ch_qscan.sv
// ch_qscan: scan/update controller for the 32-slot cluster-head Q-value bank.
// Ports: start/num_entries (scan), wr_req/wr_slot/wr_val (write), bank_* (bank), ready/done/best_* (status). Macro: CH_SKIP_EMPTY_EN.
module ch_qscan #(
  parameter int SLOTS = 32
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start,
  input  logic [5:0]  num_entries,
  input  logic        wr_req,
  input  logic [4:0]  wr_slot,
  input  logic [15:0] wr_val,
  output logic [5:0]  bank_index,
  output logic        bank_wr_en,
  output logic [15:0] bank_wdata,
  input  logic [15:0] bank_rdata,
  output logic        ready,
  output logic        done,
  output logic        best_valid,
  output logic [4:0]  best_slot,
  output logic [15:0] best_val
);

  localparam logic [5:0] MAXN = 6'(SLOTS);

  typedef enum logic [1:0] {
    IDLE, WRITE, SCAN, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [5:0]  n_q, n_d;
  logic [15:0] max_q, max_d;
  logic [4:0]  slot_q, slot_d;
  logic        found_q, found_d;
  logic [4:0]  wslot_q, wslot_d;
  logic [15:0] wval_q, wval_d;
  logic        bv_d;
  logic [4:0]  bs_d;
  logic [15:0] bq_d;
  logic [5:0]  n_clamp;
  logic        take;

  assign n_clamp = (num_entries > MAXN) ? MAXN : num_entries;

`ifdef CH_SKIP_EMPTY_EN
  // zero marks an empty slot, which may never become the winner
  assign take = (bank_rdata != 16'h0000) &&
                (!found_q || (bank_rdata > max_q));
`else
  assign take = !found_q || (bank_rdata > max_q);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    max_d   = max_q;
    slot_d  = slot_q;
    found_d = found_q;
    wslot_d = wslot_q;
    wval_d  = wval_q;
    bv_d    = best_valid;
    bs_d    = best_slot;
    bq_d    = best_val;
    unique case (state_q)
      IDLE: begin
        if (wr_req) begin
          state_d = WRITE;
          wslot_d = wr_slot;
          wval_d  = wr_val;
        end else if (start) begin
          cnt_d   = '0;
          n_d     = n_clamp;
          max_d   = '0;
          slot_d  = '0;
          found_d = 1'b0;
          bv_d    = 1'b0;
          bs_d    = '0;
          bq_d    = '0;
          state_d = (n_clamp == 6'd0) ? DONE : SCAN;
        end
      end
      WRITE: state_d = IDLE;
      SCAN: begin
        // strict compare: equal values keep the earlier (lower) slot
        if (take) begin
          max_d   = bank_rdata;
          slot_d  = cnt_q[4:0];
          found_d = 1'b1;
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == n_q - 6'd1) begin
          state_d = DONE;
          bv_d    = found_d;
          bs_d    = slot_d;
          bq_d    = max_d;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      n_q        <= '0;
      max_q      <= '0;
      slot_q     <= '0;
      found_q    <= 1'b0;
      wslot_q    <= '0;
      wval_q     <= '0;
      best_valid <= 1'b0;
      best_slot  <= '0;
      best_val   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      max_q      <= max_d;
      slot_q     <= slot_d;
      found_q    <= found_d;
      wslot_q    <= wslot_d;
      wval_q     <= wval_d;
      best_valid <= bv_d;
      best_slot  <= bs_d;
      best_val   <= bq_d;
    end
  end

  // bank pins decode from registers only
  always_comb begin
    bank_index = '0;
    bank_wr_en = 1'b0;
    bank_wdata = '0;
    unique case (state_q)
      WRITE: begin
        bank_index = {wslot_q, 1'b0};
        bank_wr_en = 1'b1;
        bank_wdata = wval_q;
      end
      SCAN:    bank_index = {cnt_q[4:0], 1'b0};
      default: bank_index = '0;
    endcase
  end

  assign ready = (state_q == IDLE);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_ch_qscan.sv
// tb_ch_qscan: directed bench for ch_qscan with a byte-wide bank model.
// Expected scan results and writes are queued; a monitor pops on done/bank_wr_en.
module tb_ch_qscan;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  num_entries = '0;
  logic        wr_req = 1'b0;
  logic [4:0]  wr_slot = '0;
  logic [15:0] wr_val = '0;
  logic [5:0]  bank_index;
  logic        bank_wr_en;
  logic [15:0] bank_wdata;
  logic [15:0] bank_rdata;
  logic        ready;
  logic        done;
  logic        best_valid;
  logic [4:0]  best_slot;
  logic [15:0] best_val;

  ch_qscan dut (
    .clk(clk), .nrst(nrst), .start(start),
    .num_entries(num_entries), .wr_req(wr_req),
    .wr_slot(wr_slot), .wr_val(wr_val),
    .bank_index(bank_index), .bank_wr_en(bank_wr_en),
    .bank_wdata(bank_wdata), .bank_rdata(bank_rdata),
    .ready(ready), .done(done), .best_valid(best_valid),
    .best_slot(best_slot), .best_val(best_val)
  );

  always #5 clk = ~clk;

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  logic [7:0] mem [64] = '{default: 8'h00};
  assign bank_rdata = {mem[bank_index], mem[{bank_index[5:1], 1'b1}]};
  always @(posedge clk)
    if (bank_wr_en) begin
      mem[bank_index] <= bank_wdata[15:8];
      mem[{bank_index[5:1], 1'b1}] <= bank_wdata[7:0];
    end

  typedef struct {
    int          due;
    logic        v;
    logic [4:0]  s;
    logic [15:0] q;
  } sexp_t;
  typedef struct {
    int          due;
    logic [5:0]  idx;
    logic [15:0] d;
  } wexp_t;

  sexp_t sq[$];
  wexp_t wq[$];
  int vecs = 0;
  int errs = 0;
  int mx;
  logic ev;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h @edge %0d", nm, act, exp, ecnt);
    end
  endtask

  task automatic monitor();
    sexp_t e;
    wexp_t w;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sq.size() == 0) begin
          vecs++; errs++;
          $display("FAIL done_unexpected: done=1 want 0 @edge %0d", ecnt);
        end else begin
          e = sq.pop_front();
          chk("done_cycle", ecnt, e.due);
          chk("best_valid", best_valid, e.v);
          chk("best_slot", best_slot, e.s);
          chk("best_val", best_val, e.q);
        end
      end
      if (bank_wr_en) begin
        if (wq.size() == 0) begin
          vecs++; errs++;
          $display("FAIL wr_unexpected: idx=%0d data=%h want no write", bank_index, bank_wdata);
        end else begin
          w = wq.pop_front();
          chk("wr_cycle", ecnt, w.due);
          chk("wr_index", bank_index, w.idx);
          chk("wr_data", bank_wdata, w.d);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!ready && k < 200) begin
      step();
      k++;
    end
    chk("ready_wait", ready, 1);
  endtask

  task automatic check_reset();
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_wr_en", bank_wr_en, 0);
    chk("rst_index", bank_index, 0);
    chk("rst_wdata", bank_wdata, 0);
    chk("rst_bvalid", best_valid, 0);
    chk("rst_bslot", best_slot, 0);
    chk("rst_bval", best_val, 0);
  endtask

  task automatic do_write(int s, logic [15:0] v);
    wait_ready();
    wr_slot = 5'(s);
    wr_val  = v;
    wr_req  = 1'b1;
    wq.push_back('{ecnt + 1, 6'(2 * s), v});
    step();
    wr_req = 1'b0;
    chk("wr_busy", ready, 0);
    step();
    chk("wr_ready_c2", ready, 1);
    chk("bank_hi", mem[2 * s], v[15:8]);
    chk("bank_lo", mem[2 * s + 1], v[7:0]);
  endtask

  task automatic do_scan(int n, logic v, logic [4:0] s,
                         logic [15:0] q, bit poke, output int m);
    int k = 0;
    int nc = (n > 32) ? 32 : n;
    int due;
    wait_ready();
    num_entries = 6'(n);
    start = 1'b1;
    due = ecnt + 1 + nc;
    sq.push_back('{due, v, s, q});
    step();
    start = 1'b0;
    if (poke) begin
      num_entries = 6'd2;
      wr_slot = 5'd9;
      wr_val = 16'hFFFF;
    end
    m = 0;
    while (!ready && k < 200) begin
      if (int'(bank_index) > m) m = int'(bank_index);
      if (poke) begin
        start  = (k == 2);
        wr_req = (k == 2);
      end
      step();
      k++;
    end
    start = 1'b0;
    wr_req = 1'b0;
    chk("scan_ready_cycle", ecnt, due + 1);
  endtask

  initial begin
    fork
      monitor();
    join_none
    repeat (3) step();
    check_reset();
    nrst = 1'b1;
    step();

    do_write(3, 16'h0100);
    do_write(7, 16'h0A00);
    do_write(12, 16'h0A00);
    do_scan(16, 1'b1, 5'd7, 16'h0A00, 1'b0, mx);

    do_write(31, 16'hFFFF);
    do_scan(40, 1'b1, 5'd31, 16'hFFFF, 1'b0, mx);
    chk("max_index", mx, 62);

    do_scan(0, 1'b0, 5'd0, 16'h0000, 1'b0, mx);

    do_write(3, 16'h0000);
    do_write(7, 16'h0000);
    do_write(12, 16'h0000);
    do_write(31, 16'h0000);
`ifdef CH_SKIP_EMPTY_EN
    ev = 1'b0;
`else
    ev = 1'b1;
`endif
    do_scan(4, ev, 5'd0, 16'h0000, 1'b0, mx);

    // write and start together: the write wins, start is dropped
    wait_ready();
    wr_slot = 5'd5;
    wr_val = 16'h1234;
    num_entries = 6'd8;
    wr_req = 1'b1;
    start = 1'b1;
    wq.push_back('{ecnt + 1, 6'd10, 16'h1234});
    step();
    wr_req = 1'b0;
    start = 1'b0;
    chk("both_busy", ready, 0);
    step();
    chk("both_ready", ready, 1);
    repeat (3) step();
    chk("both_no_scan", ready, 1);

    // start and wr_req poked mid-scan must be ignored
    do_scan(10, 1'b1, 5'd5, 16'h1234, 1'b1, mx);

    do_write(15, 16'h8000);
    do_write(19, 16'h8001);
    wait_ready();
    num_entries = 6'd20;
    start = 1'b1;
    sq.push_back('{ecnt + 21, 1'b1, 5'd19, 16'h8001});
    step();
    start = 1'b0;
    repeat (4) step();
    nrst = 1'b0;
    sq.delete();
    step();
    check_reset();
    nrst = 1'b1;
    step();
    do_scan(20, 1'b1, 5'd19, 16'h8001, 1'b0, mx);

    repeat (5) step();
    chk("pending", sq.size() + wq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/ch_qscan.md
# ch_qscan

Scan-and-update controller directly upstream of the cluster-head memory bank: 64 bytes seen as 32 big-endian 16-bit Q-value slots, addressed by a byte index, with a combinational read port. The block owns the bank's `index`, `wr_en` and `data_in` pins and consumes its `data_out`. On request it scans slots 0..N-1 and reports the slot with the largest Q-value, which is the next-hop choice for the RL routing engine. It also performs single-slot writes so Q-value updates reach the bank without conflicting with a scan.

## Interface
- `SLOTS`, 32: slot count; the bank byte index is 2×slot, 6 bits.
- `clk` in 1: single clock, rising edge.
- `nrst` in 1: synchronous, active-low reset.
- `start` in 1: scan request pulse; accepted only when `ready`=1.
- `num_entries` in 6: slots to scan, sampled on accepted `start`; values >32 are clamped to 32.
- `wr_req` in 1: write request pulse; accepted only when `ready`=1.
- `wr_slot` in 5: slot to write, sampled with `wr_req`.
- `wr_val` in 16: Q-value to write, sampled with `wr_req`.
- `bank_index` out 6: bank byte address.
- `bank_wr_en` out 1: bank write enable.
- `bank_wdata` out 16: bank write data.
- `bank_rdata` in 16: bank combinational read data for `bank_index`.
- `ready` out 1: high in IDLE only.
- `done` out 1: one-cycle pulse when a scan completes.
- `best_valid` out 1: `best_slot`/`best_val` are meaningful.
- `best_slot` out 5: winning slot.
- `best_val` out 16: winning Q-value, unsigned.

## Operation
- FSM states: IDLE, WRITE, SCAN, DONE.
- IDLE: `bank_index`=0, `bank_wr_en`=0.
  - `wr_req`=1 → WRITE.
  - Else `start`=1 → SCAN with slot counter 0, running max cleared, found flag cleared.
  - If `wr_req` and `start` are high together, the write wins and `start` is dropped. The master re-issues `start` after `ready` returns.
- WRITE (1 cycle): `bank_index`=2×`wr_slot`, `bank_wdata`=`wr_val`, `bank_wr_en`=1 → IDLE.
- SCAN: `bank_index`=2×counter; `bank_rdata` is sampled at the edge.
  - Update rule: if no entry has been accepted yet, or `bank_rdata` > running max (strict, unsigned), store the value and slot.
  - Ties keep the lower slot.
  - Counter increments each cycle; after slot `num_entries`-1 → DONE.
  - With `num_entries`=0, go directly to DONE; `best_valid`=0.
- DONE (1 cycle): `done`=1, → IDLE.
  - `best_*` are registered at DONE entry and held until the next accepted `start`. They are not cleared by writes.
- Requests outside IDLE are ignored, with no queuing.
- Counter arithmetic is 6-bit. Slot 31 maps to index 62, the last legal index; there is no wrap past slot 31.
- Reset mid-scan: return to IDLE the next edge; no `done` pulse; results cleared.

## Timing
- Reset values: `ready`=1, `done`=0, `bank_wr_en`=0, `bank_index`=0, `bank_wdata`=0, `best_valid`=0, `best_slot`=0, `best_val`=0.
- Scan latency: `start` accepted at edge E0 → slot k presented in cycle k+1.
  - `done`=1 in cycle N+1.
  - `best_*` are valid from cycle N+1 on.
  - `ready` returns in cycle N+2.
  - For N=0: `done` in cycle 1.
- Write: `wr_req` at E0 → `bank_wr_en`=1 in cycle 1; bank updated at edge E2; `ready` in cycle 2.
- Outputs are registered except `bank_index`, `bank_wr_en` and `bank_wdata`, which decode from state and registers with no input-to-output combinational path.

## Configuration
- `CH_SKIP_EMPTY_EN` defined:
  - Slots reading 0x0000 are treated as empty and never win.
  - If all scanned slots are zero, `best_valid`=0 and `best_slot`/`best_val`=0.
- Not defined:
  - Zero values compete normally.
  - Any scan with N≥1 gives `best_valid`=1. An all-zero bank yields slot 0, value 0.

## Test plan
- After reset, write slots 3=0x0100, 7=0x0A00, 12=0x0A00; scan N=16 → `done` at cycle 17, `best_slot`=7, `best_val`=0x0A00 (tie keeps the lower slot).
- Write slot 31=0xFFFF, scan N=40 → clamped to 32, `done` at cycle 33, `best_slot`=31, `bank_index` never exceeds 62.
- Scan N=0 → `done` at cycle 1, `best_valid`=0; scan N=4 on a zeroed bank → `best_valid`=0 with `CH_SKIP_EMPTY_EN`, =1 with slot 0 without.
- `wr_req` and `start` in the same cycle → only the write occurs, no `done`; `start` pulsed during a scan → ignored, `done` pulses once.
- `nrst`=0 at cycle 5 of an N=20 scan → all outputs at reset values next cycle, no `done`; rescan N=20 → correct result.
